multicycle_control_fsm: RTL

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle processor control FSM: sequences fetch, decode, memory, ALU and
// branch steps and traps on a memory handshake timeout.
// Optional feature macro: ILLEGAL_TRAP_EN (defined: illegal opcodes in DECODE
// trap; undefined: they retire as a NOP back to FETCH).
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic [6:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOpcode,
  output logic       Error,
  output logic [3:0] State
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_TRAP   = 4'd9
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_run;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_wait_state;
  logic             w_timeout;

  logic       r_mem_read;
  logic       r_mem_write;
  logic       r_reg_write;
  logic       r_mem_to_reg;
  logic       r_iord;
  logic       r_alu_src_a;
  logic       r_pc_source;
  logic [1:0] r_alu_src_b;
  logic [1:0] r_alu_op;
  logic       r_error;
  logic       r_in_fetch;
  logic       r_in_branch;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                        (r_state == S_MEMWR);
  assign w_timeout    = !MemReady && (r_wait_cnt == TO_LAST);

  // Next-state decode; r_run holds FETCH until the first edge after reset
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (!r_run)        w_next = S_FETCH;
        else if (MemReady) w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
        else               w_next = S_FETCH;
      end
      S_DECODE: begin
        if ((Opcode == OP_LOAD) || (Opcode == OP_STORE)) w_next = S_MEMADR;
        else if (Opcode == OP_RTYPE)                     w_next = S_EXEC;
        else if (Opcode == OP_BRANCH)                    w_next = S_BRANCH;
        else begin
`ifdef ILLEGAL_TRAP_EN
          w_next = S_TRAP;
`else
          w_next = S_FETCH;
`endif
        end
      end
      S_MEMADR: w_next = (Opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (MemReady)       w_next = S_MEMWB;
        else if (w_timeout) w_next = S_TRAP;
        else                w_next = S_MEMRD;
      end
      S_MEMWB: w_next = S_FETCH;
      S_MEMWR: begin
        if (MemReady)       w_next = S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
        else                w_next = S_MEMWR;
      end
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
  end

  // State register with outputs registered from the upcoming state
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state      <= S_FETCH;
      r_run        <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_iord       <= 1'b0;
      r_alu_src_a  <= 1'b0;
      r_pc_source  <= 1'b0;
      r_alu_src_b  <= 2'b00;
      r_alu_op     <= 2'b00;
      r_error      <= 1'b0;
      r_in_fetch   <= 1'b0;
      r_in_branch  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_run        <= 1'b1;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_iord       <= 1'b0;
      r_alu_src_a  <= 1'b0;
      r_pc_source  <= 1'b0;
      r_alu_src_b  <= 2'b00;
      r_alu_op     <= 2'b00;
      r_error      <= 1'b0;
      r_in_fetch   <= 1'b0;
      r_in_branch  <= 1'b0;
      case (w_next)
        S_FETCH: begin
          r_mem_read  <= 1'b1;
          r_alu_src_b <= 2'b01;
          r_in_fetch  <= 1'b1;
        end
        S_DECODE: r_alu_src_b <= 2'b11;
        S_MEMADR: begin
          r_alu_src_a <= 1'b1;
          r_alu_src_b <= 2'b10;
        end
        S_MEMRD: begin
          r_mem_read <= 1'b1;
          r_iord     <= 1'b1;
        end
        S_MEMWB: begin
          r_reg_write  <= 1'b1;
          r_mem_to_reg <= 1'b1;
        end
        S_MEMWR: begin
          r_mem_write <= 1'b1;
          r_iord      <= 1'b1;
        end
        S_EXEC: begin
          r_alu_src_a <= 1'b1;
          r_alu_op    <= 2'b10;
        end
        S_ALUWB: r_reg_write <= 1'b1;
        S_BRANCH: begin
          r_alu_src_a <= 1'b1;
          r_alu_op    <= 2'b01;
          r_pc_source <= 1'b1;
          r_in_branch <= 1'b1;
        end
        S_TRAP:  r_error <= 1'b1;
        default: r_error <= 1'b1;
      endcase
    end
  end

  // Memory-wait counter: cleared on handshake or state change
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_wait_cnt <= '0;
    end else if (!r_run || MemReady || (w_next != r_state)) begin
      r_wait_cnt <= '0;
    end else if (w_wait_state) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign MemRead   = r_mem_read;
  assign MemWrite  = r_mem_write;
  assign RegWrite  = r_reg_write;
  assign MemToReg  = r_mem_to_reg;
  assign IorD      = r_iord;
  assign ALUSrcA   = r_alu_src_a;
  assign PCSource  = r_pc_source;
  assign ALUSrcB   = r_alu_src_b;
  assign ALUOpcode = r_alu_op;
  assign Error     = r_error;
  assign State     = r_state;
  // Instruction/PC strobes follow the live handshake and zero flag
  assign IRWrite   = r_in_fetch & MemReady;
  assign PCWrite   = (r_in_fetch & MemReady) | (r_in_branch & Zero);

endmodule
